// File: rtl/mem_sram_controller.sv
// Multi-cycle 32-bit load/store controller for a 16-bit asynchronous SRAM: two half-word phases per access.
// Optional access counters (rd_count/wr_count) are built when SRAM_ACCESS_COUNT_EN is defined.
module mem_sram_controller #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in
`ifdef SRAM_ACCESS_COUNT_EN
  ,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int         WORD_W   = SRAM_ADDR_W - 1;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              is_wr;
  logic [15:0]       lo_hold;
  logic [WORD_W-1:0] word;

  // Byte address relative to BASE_ADDR, in 32-bit words; wraps modulo the SRAM size.
  function automatic logic [WORD_W-1:0] map_word(input logic [31:0] a);
    return WORD_W'((a - 32'(BASE_ADDR)) >> 2);
  endfunction

  assign word = map_word(address);

  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = ~(rd_en | wr_en);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_wr       <= 1'b0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rd_en || wr_en) begin
            // A simultaneous read request is dropped in favour of the write.
            state       <= LOW;
            is_wr       <= wr_en;
            sram_addr   <= {word, 1'b0};
            sram_we_n   <= ~wr_en;
            sram_dq_oe  <= wr_en;
            sram_dq_out <= wr_en ? write_data[15:0] : 16'h0000;
          end
        end
        LOW: begin
          if (cnt == LAST_CNT) begin
            state       <= HIGH;
            cnt         <= '0;
            sram_addr   <= {word, 1'b1};
            sram_dq_out <= is_wr ? write_data[31:16] : 16'h0000;
          end else begin
            cnt         <= cnt + 4'd1;
            sram_addr   <= {word, 1'b0};
            sram_dq_out <= is_wr ? write_data[15:0] : 16'h0000;
          end
        end
        HIGH: begin
          if (cnt == LAST_CNT) begin
            state       <= DONE;
            cnt         <= '0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_dq_out <= '0;
            if (!is_wr) read_data <= {sram_dq_in, lo_hold};
          end else begin
            cnt         <= cnt + 4'd1;
            sram_addr   <= {word, 1'b1};
            sram_dq_out <= is_wr ? write_data[31:16] : 16'h0000;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Low half is staged so read_data only changes when a whole read completes.
  always_ff @(posedge clk) begin
    if (state == LOW && cnt == LAST_CNT && !is_wr) lo_hold <= sram_dq_in;
  end

`ifdef SRAM_ACCESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == DONE) begin
      if (is_wr) wr_count <= wr_count + 32'd1;
      else       rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mem_sram_controller.md
Name: mem_sram_controller

Overview:
Multi-cycle controller that services the MEM stage's 32-bit load/store requests against an external 16-bit asynchronous SRAM.
- Each 32-bit access is split into two half-word phases: low half-word first, then high.
- Each phase is stretched by a programmable number of wait cycles.
- `ready` is held low while an access is in flight, so the pipeline freeze logic stalls upstream stages.
- Sits between MEM-stage request logic and the board SRAM pins.

Parameters:
- WAIT_CYCLES, 5: cycles per half-word phase; legal range 1..15.
- BASE_ADDR, 1024: CPU byte address that maps to SRAM word 0.
- SRAM_ADDR_W, 18: SRAM half-word address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- rd_en  in  1  load request; held stable until ready=1.
- wr_en  in  1  store request; held stable until ready=1.
- address  in  32  CPU byte address (ALU result).
- write_data  in  32  store data (Rm value).
- read_data  out  32  load result; valid in the DONE cycle and held until the next read completes.
- ready  out  1  high = no access pending or access completing this cycle.
- sram_addr  out  SRAM_ADDR_W  SRAM half-word address.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_dq_out  out  16  write data driven to the SRAM.
- sram_dq_oe  out  1  high = controller drives the data bus.
- sram_dq_in  in  16  read data sampled from the SRAM.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE; wait counter = 0.
  - read_data=0, sram_addr=0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
  - Any access in flight is abandoned; no further SRAM strobes.
- State machine: IDLE -> LOW -> HIGH -> DONE -> IDLE.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational.
  - Either request moves the FSM to LOW at the next edge.
  - The operation type is latched at that edge. If both rd_en and wr_en are high, the write wins and the read is dropped.
  - Address and data are used as presented each cycle; the requester holds them stable.
- LOW and HIGH:
  - Each phase lasts exactly WAIT_CYCLES cycles, timed by a 4-bit counter.
  - ready=0 throughout both phases.
- Address mapping:
  - word = ((address - BASE_ADDR) >> 2), truncated to SRAM_ADDR_W-1 bits (wraps modulo).
  - sram_addr = {word, 0} in LOW and {word, 1} in HIGH.
  - address[1:0] is ignored.
- Writes:
  - sram_dq_oe=1 and sram_we_n=0 for every cycle of both phases.
  - sram_dq_out = write_data[15:0] in LOW and write_data[31:16] in HIGH.
- Reads:
  - sram_we_n=1 and sram_dq_oe=0.
  - sram_dq_in is captured on the last cycle of LOW into read_data[15:0].
  - sram_dq_in is captured on the last cycle of HIGH into read_data[31:16].
- DONE:
  - Lasts one cycle; ready=1.
  - SRAM outputs return to idle values.
  - Next state is IDLE unconditionally.
  - A held request seen in the following IDLE cycle is treated as a new access.
- Timing:
  - If a request is first seen in IDLE at cycle 0, ready is low for cycles 0..2*WAIT_CYCLES and high in cycle 2*WAIT_CYCLES+1.
  - A back-to-back access therefore starts one cycle after DONE.
- Request changes mid-access: a change on rd_en or wr_en during LOW or HIGH does not abort the access. Behaviour for a changed address is undefined.

Optional Feature:
Macro SRAM_ACCESS_COUNT_EN.
- When defined, adds two ports:
  - rd_count  out  32: increments by 1 in each DONE cycle of a read.
  - wr_count  out  32: increments by 1 in each DONE cycle of a write.
- Both counters reset to 0 on rst=0 and wrap from 0xFFFFFFFF to 0.
- When not defined, neither the ports nor the counter logic exist; all other behaviour is identical.

Test Plan:
- Read timing, WAIT_CYCLES=5:
  - Stimulus: address=1024, rd_en=1; SRAM model returns 0xBEEF at sram_addr 0 and 0xDEAD at sram_addr 1.
  - Required: ready low for 11 cycles; read_data=0xDEADBEEF in the DONE cycle; sram_we_n stays 1.
- Write mapping:
  - Stimulus: address=1032, write_data=0x12345678, wr_en=1.
  - Required: sram_addr=4 with dq_out=0x5678, then sram_addr=5 with dq_out=0x1234; each for 5 cycles with we_n=0 and dq_oe=1; ready returns high in the 12th cycle.
- Simultaneous requests:
  - Stimulus: rd_en=1 and wr_en=1 together.
  - Required: write sequence only; read_data unchanged from its previous value.
- Back-to-back:
  - Stimulus: read completes, then rd_en is held at 1 with a new address.
  - Required: second access starts in the IDLE cycle after DONE; ready pattern is 0x11, 1, 0x11, 1.
- Reset mid-access:
  - Stimulus: rst=0 in the 3rd cycle of HIGH during a write.
  - Required: at the next edge we_n=1, dq_oe=0, sram_addr=0, read_data=0; FSM in IDLE; ready=1 when there is no request.
- With SRAM_ACCESS_COUNT_EN defined:
  - Stimulus: 3 reads and 2 writes.
  - Required: rd_count=3, wr_count=2; both read 0 after reset.
